ram_test_checker: RTL and testbench



---
 rtl/ram_test_checker.sv | 137 +++++++++++++
 tb/tb_ram_test_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_test_checker.sv
// ram_test_checker: sweeps all 4096 words of RAM port B and compares each word
// against {addr[7:0] + SEED, LOW_BYTE}. It reports the mismatch count and the
// first failing address/data. Port B is used read-only.
module ram_test_checker #(
  parameter int          READ_LATENCY = 2,
  parameter logic [7:0]  LOW_BYTE     = 8'hE8,
  parameter logic [7:0]  SEED         = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [11:0] addr_b,
  output logic [15:0] data_b,
  output logic        we_b,
  input  logic [15:0] q_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [12:0] err_count,
  output logic [11:0] first_err_addr,
  output logic [15:0] first_err_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [11:0] LAST_ADDR = 12'hFFF;
  localparam logic [12:0] MAX_ERR   = 13'h1000;

  state_t state;

  // Stage 0 always mirrors the address currently on addr_b. The last stage
  // holds the address whose data is on q_b this cycle.
  logic [READ_LATENCY-1:0]       pipe_v;
  logic [READ_LATENCY-1:0][11:0] pipe_a;

  logic [7:0]  exp_hi;
  logic [15:0] expected;
  logic        mismatch;
  logic [12:0] err_next;
  logic        more_pending;

  // The port is read-only, so write data and write enable are tied off.
  assign data_b = 16'h0000;
  assign we_b   = 1'b0;

  // Build the expected word for the popping entry and decide whether entries
  // remain in flight after this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    more_pending = 1'b0;
    exp_hi   = pipe_a[READ_LATENCY-1][7:0] + SEED;
    expected = {exp_hi, LOW_BYTE};
    mismatch = pipe_v[READ_LATENCY-1] && (q_b != expected);
    err_next = (mismatch && (err_count != MAX_ERR)) ? err_count + 13'd1 : err_count;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      more_pending = more_pending | pipe_v[i];
    end
  end

  // Sweep FSM, delay line and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_b         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pipe_v         <= '0;
      // NOTE: the delay-line addresses are cleared along with the valids so
      // that no register holds an undefined value after reset.
      pipe_a         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side below sees the pre-edge value.
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      pipe_v[0] <= 1'b0;

      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0) begin
          first_err_addr <= pipe_a[READ_LATENCY-1];
          first_err_data <= q_b;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= READ;
            addr_b         <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pipe_v[0]      <= 1'b1;
            pipe_a[0]      <= '0;
          end
        end
        READ: begin
          if (addr_b == LAST_ADDR) begin
            // The address stays at the top of the array; nothing new is issued.
            if (!more_pending) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              state <= DRAIN;
            end
          end else begin
            addr_b    <= addr_b + 12'd1;
            pipe_v[0] <= 1'b1;
            pipe_a[0] <= addr_b + 12'd1;
          end
        end
        DRAIN: begin
          if (!more_pending) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_test_checker.sv
// Bench for ram_test_checker. Two instances are used: A has the defaults
// (latency 2, seed 0) and B has latency 1 and seed 8'h05. Each instance has its
// own RAM model. Expected sweep results are queued when start is issued. A
// monitor per instance pops and compares them when done rises.
module tb_ram_test_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b;

  logic [11:0] addr_a, addr_b;
  logic [15:0] data_a, data_b, q_a, q_b;
  logic        we_a, we_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [12:0] err_a, err_b;
  logic [11:0] fea_a, fea_b;
  logic [15:0] fed_a, fed_b;

  logic [15:0] mem_a [4096];
  logic [15:0] mem_b [4096];
  logic [15:0] rd_a;

  // RAM A: one output register, so the data arrives two edges after the address.
  always @(posedge clk) rd_a <= mem_a[addr_a];
  assign q_a = rd_a;
  // RAM B: the read is combinational, so the data arrives one edge after the address.
  assign q_b = mem_b[addr_b];

  ram_test_checker #(.READ_LATENCY(2), .LOW_BYTE(8'hE8), .SEED(8'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .addr_b(addr_a), .data_b(data_a),
    .we_b(we_a), .q_b(q_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_addr(fea_a), .first_err_data(fed_a));

  ram_test_checker #(.READ_LATENCY(1), .LOW_BYTE(8'hE8), .SEED(8'h05)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .addr_b(addr_b), .data_b(data_b),
    .we_b(we_b), .q_b(q_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_addr(fea_b), .first_err_data(fed_b));

  typedef struct {
    logic [12:0] err;
    logic [11:0] fa;
    logic [15:0] fd;
    logic        pass;
    int          done_edge;
  } exp_t;

  exp_t q_exp_a[$];
  exp_t q_exp_b[$];
  exp_t ea, eb;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit bus_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor A: compare results and the done timing on each rising edge of done.
  logic done_a_prev = 1'b0;
  always @(negedge clk) begin
    if (done_a && !done_a_prev) begin
      if (q_exp_a.size() == 0) check("a unexpected done", 32'd1, 32'd0);
      else begin
        ea = q_exp_a.pop_front();
        check("a err_count", 32'(err_a), 32'(ea.err));
        check("a first_err_addr", 32'(fea_a), 32'(ea.fa));
        check("a first_err_data", 32'(fed_a), 32'(ea.fd));
        check("a pass", 32'(pass_a), 32'(ea.pass));
        check("a done edge", 32'(cyc - 1), 32'(ea.done_edge));
        check("a busy at done", 32'(busy_a), 32'd0);
      end
    end
    done_a_prev = done_a;
  end

  // Monitor B: same comparisons for the latency-1, seed-5 instance.
  logic done_b_prev = 1'b0;
  always @(negedge clk) begin
    if (done_b && !done_b_prev) begin
      if (q_exp_b.size() == 0) check("b unexpected done", 32'd1, 32'd0);
      else begin
        eb = q_exp_b.pop_front();
        check("b err_count", 32'(err_b), 32'(eb.err));
        check("b first_err_addr", 32'(fea_b), 32'(eb.fa));
        check("b first_err_data", 32'(fed_b), 32'(eb.fd));
        check("b pass", 32'(pass_b), 32'(eb.pass));
        check("b done edge", 32'(cyc - 1), 32'(eb.done_edge));
      end
    end
    done_b_prev = done_b;
  end

  // Latch any write activity on either port so it can be reported at the end.
  always @(negedge clk) begin
    if (we_a !== 1'b0 || data_a !== 16'h0 || we_b !== 1'b0 || data_b !== 16'h0)
      bus_bad = 1'b1;
  end

  // Queue the expected result and pulse start. Right after the start edge,
  // check that the results were cleared.
  task automatic issue(input bit which, input logic [12:0] err, input logic [11:0] fa,
                       input logic [15:0] fd, input logic pass);
    exp_t e;
    @(negedge clk);
    e.err = err; e.fa = fa; e.fd = fd; e.pass = pass;
    e.done_edge = cyc + (which ? 4096 : 4097);
    if (which) begin q_exp_b.push_back(e); start_b = 1'b1; end
    else       begin q_exp_a.push_back(e); start_a = 1'b1; end
    @(posedge clk);
    #1;
    if (which) begin
      check("b busy after start", 32'(busy_b), 32'd1);
      check("b err cleared", 32'(err_b), 32'd0);
    end else begin
      check("a busy after start", 32'(busy_a), 32'd1);
      check("a done cleared", 32'(done_a), 32'd0);
      check("a err cleared", 32'(err_a), 32'd0);
      check("a first_err cleared", 32'({fea_a, fed_a}), 32'd0);
      check("a addr after start", 32'(addr_a), 32'd0);
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Wait, with a bound, until the monitor has consumed the expected result.
  task automatic wait_result(input bit which);
    for (int i = 0; i < 6000; i++) begin
      if ((which ? q_exp_b.size() : q_exp_a.size()) == 0) break;
      @(negedge clk);
    end
    if ((which ? q_exp_b.size() : q_exp_a.size()) != 0) begin
      check(which ? "b sweep timeout" : "a sweep timeout", 32'd1, 32'd0);
      if (which) q_exp_b.delete(); else q_exp_a.delete();
    end
    @(negedge clk);
  endtask

  // Wait, with a bound, until RAM A's address bus shows the given address.
  task automatic wait_addr_a(input logic [11:0] target);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (addr_a == target) break;
    end
    if (i == 5000) check("a address wait timeout", 32'd1, 32'd0);
  endtask

  task automatic fill_a_good();
    for (int i = 0; i < 4096; i++) mem_a[i] = {8'(i), 8'hE8};
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    fill_a_good();
    for (int i = 0; i < 4096; i++) mem_b[i] = {8'(i) + 8'h05, 8'hE8};
    #22;
    check("reset addr", 32'(addr_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset pass", 32'(pass_a), 32'd0);
    check("reset err", 32'(err_a), 32'd0);
    check("reset first_err", 32'({fea_a, fed_a}), 32'd0);
    check("reset b done", 32'({busy_b, done_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Sweep over a clean image.
    issue(1'b0, 13'd0, 12'h000, 16'h0000, 1'b1);
    wait_result(1'b0);

    // One corrupted word.
    mem_a[12'h123] = 16'hFFFF;
    issue(1'b0, 13'd1, 12'h123, 16'hFFFF, 1'b0);
    wait_result(1'b0);

    // Every low byte wrong: the count saturates at 4096 and does not wrap.
    for (int i = 0; i < 4096; i++) mem_a[i] = {8'(i), 8'h00};
    issue(1'b0, 13'd4096, 12'h000, 16'h0000, 1'b0);
    wait_result(1'b0);

    // Start from DONE clears the 4096 count. A start seen during READ is
    // ignored, so the done edge does not move.
    fill_a_good();
    issue(1'b0, 13'd0, 12'h000, 16'h0000, 1'b1);
    wait_addr_a(12'd100);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a start ignored in READ", 32'({busy_a, addr_a}), 32'({1'b1, 12'd101}));
    wait_result(1'b0);

    // A second sweep, started from DONE.
    issue(1'b0, 13'd0, 12'h000, 16'h0000, 1'b1);
    wait_result(1'b0);

    // Reset in mid-sweep: the sweep is abandoned and done never pulses.
    issue(1'b0, 13'd0, 12'h000, 16'h0000, 1'b1);
    wait_addr_a(12'd2000);
    rst_n = 1'b0;
    #1;
    q_exp_a.delete();
    check("midreset addr", 32'(addr_a), 32'd0);
    check("midreset flags", 32'({busy_a, done_a, pass_a}), 32'd0);
    check("midreset results", 32'({err_a, fea_a, fed_a}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post reset idle", 32'({busy_a, done_a, addr_a}), 32'd0);

    issue(1'b0, 13'd0, 12'h000, 16'h0000, 1'b1);
    wait_result(1'b0);

    // Latency 1 with seed 5: done appears one edge earlier than with latency 2.
    issue(1'b1, 13'd0, 12'h000, 16'h0000, 1'b1);
    wait_result(1'b1);

    check("write port idle", 32'(bus_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
